// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_START = 2'd1,
    S_WAIT_DONE  = 2'd2
  } uart_tx_disp_state_t;

  // Occupancy counter width: must be able to hold the value DEPTH itself.
  function automatic int fifo_level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_sync_fifo_mem.sv
// Circular byte store with wrap-around pointers and registered occupancy flags.
// The caller guarantees push only when not full and pop only when not empty;
// flush clears pointers and level and wins over a same-cycle push/pop.
module uart_sync_fifo_mem
  import uart_pkg::*;
#(
  parameter int  DEPTH  = 16,
  parameter int  DATA_W = UART_DATA_W,
  localparam int AW     = $clog2(DEPTH),
  localparam int LW     = fifo_level_w(DEPTH)
) (
  input  logic              clk,
  input  logic              Resetn,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [LW-1:0]     level
);

  logic [DATA_W-1:0] store [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level_nxt;

  // Head of queue is always presented; the dispatcher latches it at launch.
  assign rd_data = store[rd_ptr];

  // Next occupancy: simultaneous push and pop cancel, flush empties.
  always_comb begin
    level_nxt = level;
    if (flush) begin
      level_nxt = '0;
    end else begin
      case ({push, pop})
        2'b10:   level_nxt = level + LW'(1);
        2'b01:   level_nxt = level - LW'(1);
        default: level_nxt = level;
      endcase
    end
  end

  // Pointers and status flags; flags track the post-edge level.
  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
      level <= level_nxt;
      full  <= (level_nxt == LW'(DEPTH));
      empty <= (level_nxt == '0);
    end
  end

  // Storage write; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push && !flush) store[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo_dispatch.sv
// Transmit-side byte buffer: queues bytes from the register block and hands
// them one at a time to the transmitter, paced by its busy flag.
// Optional low-water interrupt is built when UART_TX_FIFO_IRQ_EN is defined.
module uart_tx_fifo_dispatch
  import uart_pkg::*;
#(
  parameter int  DEPTH  = 16,
  parameter int  DATA_W = UART_DATA_W,
`ifdef UART_TX_FIFO_IRQ_EN
  parameter int  THRESH = 4,
`endif
  localparam int LW     = fifo_level_w(DEPTH)
) (
  input  logic              clk,
  input  logic              Resetn,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flush,
  input  logic              clr_overrun,
  output logic              full,
  output logic              empty,
  output logic [LW-1:0]     level,
  output logic              overrun,
  output logic              tx_enable,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_busy
`ifdef UART_TX_FIFO_IRQ_EN
  ,
  output logic              tx_irq
`endif
);

  uart_tx_disp_state_t state;
  logic                push_ok;
  logic                launch;
  logic [DATA_W-1:0]   rd_data;

  // A push is judged against the registered full flag, so a same-cycle pop
  // cannot rescue it.
  assign push_ok = wr_en && !full;
  assign launch  = (state == S_IDLE) && !empty && !tx_busy && !flush;

  uart_sync_fifo_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk     (clk),
    .Resetn  (Resetn),
    .push    (push_ok),
    .pop     (launch),
    .flush   (flush),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  // Sticky overrun; a rejected push outranks a same-cycle clear.
  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      overrun <= 1'b0;
    end else if (wr_en && full) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

  // Dispatch FSM: one Enable pulse per byte, then wait for the transmitter to
  // go busy and fall idle again before the next launch. Flush leaves it alone.
  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      state     <= S_IDLE;
      tx_enable <= 1'b0;
      tx_data   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (launch) begin
            tx_data   <= rd_data;
            tx_enable <= 1'b1;
            state     <= S_WAIT_START;
          end
        end
        S_WAIT_START: begin
          tx_enable <= 1'b0;
          if (tx_busy) state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (!tx_busy) state <= S_IDLE;
        end
        default: begin
          tx_enable <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

`ifdef UART_TX_FIFO_IRQ_EN
  logic [LW-1:0] irq_level_nxt;
  logic          armed;
  logic          armed_nxt;

  // Post-edge occupancy, so the interrupt lines up with the level output.
  always_comb begin
    irq_level_nxt = level;
    if (flush) begin
      irq_level_nxt = '0;
    end else if (push_ok && !launch) begin
      irq_level_nxt = level + LW'(1);
    end else if (!push_ok && launch) begin
      irq_level_nxt = level - LW'(1);
    end
  end

  // Interrupt stays quiet until something has been queued since the last clear.
  assign armed_nxt = !flush && (armed || push_ok);

  // Low-water interrupt, registered.
  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      armed  <= 1'b0;
      tx_irq <= 1'b0;
    end else begin
      armed  <= armed_nxt;
      tx_irq <= armed_nxt && (irq_level_nxt <= LW'(THRESH));
    end
  end
`endif

endmodule
